// File: rtl/wght_fetch.sv
// Weight fetch engine: streams a burst of BRAM words (with address wrap) into a
// 4-entry FIFO and out over a valid/ready port, flagging the final beat.
module wght_fetch #(
  parameter int BIT_WIDTH      = 31,
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [RAM_ADDR_WIDTH:0]   len,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH-1:0] raddr,
  output logic                      ren,
  input  logic [BIT_WIDTH:0]        rdat,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [BIT_WIDTH:0]        m_data,
  output logic                      m_last
);

  localparam int AW     = RAM_ADDR_WIDTH;
  localparam int DATA_W = BIT_WIDTH + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0]   ONE       = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q;
  logic              busy_q, done_q, ren_q;
  logic              rd_vld_p1_q;
  logic [AW-1:0]     raddr_q;
  logic [AW:0]       reads_left_q, beats_left_q;
  logic [DATA_W-1:0] fifo_mem [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q, cnt_d;
  logic              push, pop, room;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  assign push = rd_vld_p1_q;
  assign pop  = m_valid & m_ready;

  // Slots already claimed = occupancy after this edge plus the read still in flight.
  always_comb begin
    cnt_d = cnt_q + 3'(push) - 3'(pop);
    room  = (cnt_d + 3'(ren_q)) < 3'd4;
  end

  // Stage p1: read data returns one cycle after ren and lands in the FIFO
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      rd_vld_p1_q  <= 1'b0;
      reads_left_q <= '0;
      beats_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      done_q      <= 1'b0;
      ren_q       <= 1'b0;
      rd_vld_p1_q <= ren_q;
      cnt_q       <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 2'd1;
        beats_left_q <= beats_left_q - ONE;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= RUN;
              busy_q       <= 1'b1;
              ren_q        <= 1'b1;
              raddr_q      <= base_addr;
              reads_left_q <= len - ONE;
              beats_left_q <= len;
            end
          end
        end
        RUN: begin
          if (reads_left_q == '0) begin
            state_q <= FLUSH;
          end else if (room) begin
            ren_q        <= 1'b1;
            raddr_q      <= next_addr(raddr_q);
            reads_left_q <= reads_left_q - ONE;
          end
        end
        FLUSH: begin
          if (pop && m_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ren     = ren_q;
  assign raddr   = raddr_q;
  assign m_valid = (cnt_q != 3'd0);
  assign m_data  = m_valid ? fifo_mem[rd_ptr_q] : '0;
  assign m_last  = m_valid && (beats_left_q == ONE);

endmodule

// File: tb/tb_wght_fetch.sv
// Scoreboard bench for wght_fetch: BRAM model holds mem[a]=a+100, expected
// addresses and beats are queued at start and retired as the DUT produces them.
module tb_wght_fetch;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst, start, m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, ren, m_valid, m_last;
  logic [AW-1:0] raddr;
  logic [31:0]   rdat, m_data;

  wght_fetch #(.BIT_WIDTH(31), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .raddr(raddr), .ren(ren), .rdat(rdat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ren) rdat <= 32'(raddr) + 32'd100;

  int            n_vec = 0, n_err = 0;
  int            ren_cnt = 0, beat_cnt = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic          stall = 1'b0, stall_last;
  logic [31:0]   stall_data;
  logic [32:0]   e_m;
  logic [AW-1:0] a_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (ren) begin
        ren_cnt++;
        if (addr_q.size() == 0) chk("extra_ren", 1, 0);
        else begin
          a_m = addr_q.pop_front();
          chk("raddr", raddr, a_m);
        end
      end
      if (stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, stall_data);
        chk("hold_last", m_last, stall_last);
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e_m = exp_q.pop_front();
          chk("beat_data", m_data, e_m[31:0]);
          chk("beat_last", m_last, e_m[32]);
        end
      end
      stall      = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % DEPTH;
      addr_q.push_back(AW'(a));
      exp_q.push_back({i == n - 1, 32'(a + 100)});
    end
  endtask

  task automatic pulse_start(input int b, input int n, input bit accept);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW + 1)'(n);
    if (accept) expect_burst(b, n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, seen, 1);
    if (seen) chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_reads_left"}, addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; m_ready = 1'b1; base_addr = '0; len = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ren", ren, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    tick();

    // Basic burst with exact cycle timing
    pulse_start(4, 5, 1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("A_ren", ren, (c >= 1 && c <= 5));
      chk("A_valid", m_valid, (c >= 3 && c <= 7));
      chk("A_done", done, (c == 8));
      chk("A_busy", busy, (c <= 7));
    end
    tick();
    chk("A_drained", exp_q.size(), 0);

    // Address wrap
    pulse_start(30, 4, 1);
    wait_done("B", 20);

    // Backpressure
    m_ready = 1'b0; ren_cnt = 0; beat_cnt = 0;
    pulse_start(10, 8, 1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 8) begin
        chk("C_valid_stall", m_valid, 1);
        chk("C_data_stall", m_data, 110);
      end
    end
    chk("C_reads_before_release", (ren_cnt <= 4), 1);
    tick();
    m_ready = 1'b1;
    wait_done("C", 40);
    chk("C_beats", beat_cnt, 8);

    // Zero-length request
    ren_cnt = 0; beat_cnt = 0;
    pulse_start(7, 0, 0);
    @(negedge clk);
    chk("D_done", done, 1);
    chk("D_busy", busy, 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("D_done_after", done, 0);
      chk("D_busy_after", busy, 0);
      chk("D_valid", m_valid, 0);
    end
    chk("D_ren", ren_cnt, 0);
    tick();

    // Reset while beat 3 of 8 is pending
    m_ready = 1'b1;
    pulse_start(2, 8, 1);
    repeat (4) tick();
    m_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    tick();
    chk("E_valid", m_valid, 0);
    chk("E_busy", busy, 0);
    chk("E_ren", ren, 0);
    chk("E_done", done, 0);
    chk("E_last", m_last, 0);
    rst = 1'b0;
    beat_cnt = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("E_no_done", seen_done, 0);
    chk("E_no_beats", beat_cnt, 0);
    m_ready = 1'b1;
    pulse_start(20, 3, 1);
    wait_done("E2", 20);

    // Start while busy is ignored
    beat_cnt = 0;
    pulse_start(0, 6, 1);
    tick();
    pulse_start(15, 3, 0);
    wait_done("F", 30);
    chk("F_beats", beat_cnt, 6);

    // Start in the same cycle as done
    pulse_start(25, 3, 1);
    wait_done("G1", 20);
    pulse_start(9, 2, 1);
    wait_done("G2", 20);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wght_fetch.md
WGHT_FETCH -- requirements
Module: wght_fetch

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 31, meaning data word is BIT_WIDTH+1 bits wide (32 by default).
REQ-002 SHALL have parameter RAM_DEPTH, default 32, meaning the number of addressable weight words.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default $clog2(RAM_DEPTH), meaning the BRAM address width (AW).
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clock domain.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to fetch a burst; sampled only in IDLE.
REQ-008 base_addr  in  AW  first BRAM address of the burst; sampled with start.
REQ-009 len  in  AW+1  number of words to fetch, 0..2*RAM_DEPTH-1; sampled with start.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse at burst completion.
REQ-012 raddr  out  AW  BRAM read address, registered.
REQ-013 ren  out  1  BRAM read enable, registered.
REQ-014 rdat  in  BIT_WIDTH+1  BRAM read data, valid exactly one cycle after ren.
REQ-015 m_valid  out  1  output beat valid.
REQ-016 m_ready  in  1  downstream accepts the beat.
REQ-017 m_data  out  BIT_WIDTH+1  output weight word.
REQ-018 m_last  out  1  high with the final beat of a burst.

Function
REQ-019 FSM states: IDLE, RUN, FLUSH. IDLE->RUN on start with len>0; RUN->FLUSH when the last ren is issued; FLUSH->IDLE when the last beat handshakes (m_valid & m_ready & m_last).
REQ-020 start with len=0 SHALL issue no ren and no beat, and SHALL pulse done in the next cycle.
REQ-021 start while busy SHALL be ignored, with no effect on the running burst.
REQ-022 The first ren SHALL be asserted in the cycle after the start, with raddr=base_addr; each subsequent ren increments raddr by 1, wrapping from RAM_DEPTH-1 to 0.
REQ-023 Exactly len ren pulses SHALL be issued per burst.
REQ-024 rdat SHALL be captured the cycle after each ren into a 4-entry output FIFO.
REQ-025 ren SHALL be issued only when FIFO occupancy plus reads in flight is below 4, so the FIFO never overflows.
REQ-026 The first m_valid SHALL appear 3 cycles after the start cycle.
REQ-027 With m_ready held high, the block SHALL sustain 1 beat per cycle.
REQ-028 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable and m_valid SHALL stay high.
REQ-029 Beats SHALL be emitted in address order, with no loss or duplication.
REQ-030 m_last=1 SHALL be asserted only on beat number len.
REQ-031 done SHALL pulse in the cycle after the last-beat handshake; busy deasserts in the same cycle done pulses.
REQ-032 A start arriving in the cycle done pulses SHALL be accepted, because the FSM is in IDLE.

Reset
REQ-033 While rst=1, the block SHALL go to IDLE and drive busy=0, done=0, ren=0, raddr=0, m_valid=0, m_last=0, m_data=0, and clear the FIFO.
REQ-034 Reset mid-burst SHALL abort the burst: all outputs reset next edge, with no done pulse and no further beats.
REQ-035 Reset SHALL take priority over start in the same cycle.

Verification
REQ-036 BRAM preloaded mem[a]=a+100; base=4, len=5, m_ready=1 -> ren on cycles 1..5 with raddr 4..8; beats 104..108 on cycles 3..7; m_last on 108; done on cycle 8.
REQ-037 Wrap case: base=30, len=4, RAM_DEPTH=32 -> raddr 30,31,0,1; beats 130,131,100,101.
REQ-038 Backpressure: len=8, m_ready=0 for cycles 3..12 -> at most 4 reads issued before stall, m_data stable at 100+base, all 8 beats delivered in order after release.
REQ-039 len=0 -> no ren, no m_valid, done pulse in cycle 1, busy stays 0.
REQ-040 rst asserted while beat 3 of 8 is pending -> next cycle m_valid=0, busy=0, ren=0, no done; a new start then fetches correctly from its own base_addr.
REQ-041 start pulsed again during a busy burst -> ignored; beat count equals the original len.
